// File: rtl/ps2_kbd_ctrl_if.sv
// PS/2 keyboard link and decoded key status, bundled for the keyboard controller.
interface ps2_kbd_ctrl_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       is_press;
  logic [7:0] count;
  logic [7:0] key;

  modport master (
    output ps2_clk, ps2_data,
    input  is_press, count, key
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output is_press, count, key
  );
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard front end: deserialises device-to-host frames and decodes set-2
// make/break codes into the current key, a held flag and a press counter.
module ps2_kbd_ctrl #(
  parameter logic [15:0] TIMEOUT = 16'd20000
) (
  input  logic           clk,
  input  logic           rst,
  ps2_kbd_ctrl_if.slave  bus
);

  logic [2:0]  sclk_q;
  logic [1:0]  sdat_q;
  logic        fel;
  logic        din;

  logic [3:0]  bitcnt_q, bitcnt_d;
  logic [9:0]  shreg_q,  shreg_d;
  logic [15:0] tcnt_q,   tcnt_d;
  logic        bvalid_q, bvalid_d;
  logic [7:0]  byte_q,   byte_d;
  logic        frame_ok;

  logic        brk_q,   brk_d;
  logic        ext_q,   ext_d;
  logic        press_q, press_d;
  logic [7:0]  key_q,   key_d;
  logic [7:0]  count_q, count_d;

  assign fel = sclk_q[2] & ~sclk_q[1];
  assign din = sdat_q[1];

  // Bits enter at the top, so after ten shifts: [0]=start, [8:1]=data, [9]=parity.
  assign frame_ok = ~shreg_q[0] & din & (^shreg_q[9:1]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_q   <= '1;
      sdat_q   <= '1;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      tcnt_q   <= '0;
      bvalid_q <= 1'b0;
      byte_q   <= '0;
      brk_q    <= 1'b0;
      ext_q    <= 1'b0;
      press_q  <= 1'b0;
      key_q    <= '0;
      count_q  <= '0;
    end else begin
      sclk_q   <= {sclk_q[1:0], bus.ps2_clk};
      sdat_q   <= {sdat_q[0], bus.ps2_data};
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      tcnt_q   <= tcnt_d;
      bvalid_q <= bvalid_d;
      byte_q   <= byte_d;
      brk_q    <= brk_d;
      ext_q    <= ext_d;
      press_q  <= press_d;
      key_q    <= key_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    tcnt_d   = tcnt_q;
    bvalid_d = 1'b0;
    byte_d   = byte_q;
    if (fel) begin
      tcnt_d = '0;
      if (bitcnt_q == 4'd10) begin
        bitcnt_d = '0;
        shreg_d  = '0;
        bvalid_d = frame_ok;
        if (frame_ok) byte_d = shreg_q[8:1];
      end else begin
        bitcnt_d = bitcnt_q + 4'd1;
        shreg_d  = {din, shreg_q[9:1]};
      end
    end else if (bitcnt_q != 4'd0) begin
      if (tcnt_q == TIMEOUT - 16'd1) begin
        bitcnt_d = '0;
        shreg_d  = '0;
        tcnt_d   = '0;
      end else begin
        tcnt_d = tcnt_q + 16'd1;
      end
    end else begin
      tcnt_d = '0;
    end
  end

  always_comb begin
    brk_d   = brk_q;
    ext_d   = ext_q;
    press_d = press_q;
    key_d   = key_q;
    count_d = count_q;
    if (bvalid_q) begin
      if (byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (byte_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (brk_q) begin
        press_d = 1'b0;
        brk_d   = 1'b0;
        ext_d   = 1'b0;
      end else begin
        // Typematic repeat of the held key is not a new press.
        if (!press_q || byte_q != key_q) count_d = count_q + 8'd1;
        key_d   = byte_q;
        press_d = 1'b1;
        ext_d   = 1'b0;
      end
    end
  end

  assign bus.is_press = press_q;
  assign bus.count    = count_q;
  assign bus.key      = key_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: drives PS/2 frames and checks key/count/is_press.
module tb_ps2_kbd_ctrl;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  ps2_kbd_ctrl_if bus();

  ps2_kbd_ctrl #(.TIMEOUT(16'd400)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send_bit(input logic b);
    @(negedge clk);
    bus.ps2_data = b;
    repeat (3) @(negedge clk);
    bus.ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_ok = 1'b1,
                            input logic stop = 1'b1);
    logic [10:0] f;
    logic        par;
    par = par_ok ? ~(^b) : (^b);
    f   = {stop, par, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(f[i]);
    bus.ps2_data = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic send_partial(input int n);
    send_bit(1'b0);
    for (int i = 1; i < n; i++) send_bit(1'b1);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [7:0] k,
                             input logic [7:0] c, input logic p);
    chk({tag, "/key"},      bus.key,              k);
    chk({tag, "/count"},    bus.count,            c);
    chk({tag, "/is_press"}, {7'd0, bus.is_press}, {7'd0, p});
  endtask

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    rst          = 1'b0;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (4) @(negedge clk);
    check_state("reset", 8'h00, 8'h00, 1'b0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    send_frame(8'h1C); check_state("make_1C", 8'h1C, 8'h01, 1'b1);
    send_frame(8'hF0); check_state("f0_only", 8'h1C, 8'h01, 1'b1);
    send_frame(8'h1C); check_state("brk_1C",  8'h1C, 8'h01, 1'b0);

    send_frame(8'h1C); check_state("typ_1",   8'h1C, 8'h02, 1'b1);
    send_frame(8'h1C); check_state("typ_2",   8'h1C, 8'h02, 1'b1);
    send_frame(8'h1C); check_state("typ_3",   8'h1C, 8'h02, 1'b1);
    send_frame(8'hF0);
    send_frame(8'h1C); check_state("typ_brk", 8'h1C, 8'h02, 1'b0);

    send_frame(8'h1C, 1'b0); check_state("bad_par",  8'h1C, 8'h02, 1'b0);
    send_frame(8'h45, 1'b1, 1'b0); check_state("bad_stop", 8'h1C, 8'h02, 1'b0);
    send_frame(8'h32); check_state("make_32", 8'h32, 8'h03, 1'b1);
    send_frame(8'hF0);
    send_frame(8'h32); check_state("brk_32",  8'h32, 8'h03, 1'b0);

    send_frame(8'hE0); check_state("e0_only", 8'h32, 8'h03, 1'b0);
    send_frame(8'h75); check_state("ext_make", 8'h75, 8'h04, 1'b1);
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h75); check_state("ext_brk", 8'h75, 8'h04, 1'b0);

    send_frame(8'h1C); check_state("roll_a", 8'h1C, 8'h05, 1'b1);
    send_frame(8'h32); check_state("roll_b", 8'h32, 8'h06, 1'b1);
    send_frame(8'hF0);
    send_frame(8'h1C); check_state("roll_brk", 8'h32, 8'h06, 1'b0);

    // Abandoned partial frame must be discarded before the next one arrives.
    send_partial(5);
    bus.ps2_data = 1'b1;
    repeat (500) @(negedge clk);
    send_frame(8'h45); check_state("after_tmo", 8'h45, 8'h07, 1'b1);
    send_frame(8'hF0);
    send_frame(8'h45); check_state("tmo_brk",   8'h45, 8'h07, 1'b0);

    send_frame(8'h1C); check_state("pre_rst", 8'h1C, 8'h08, 1'b1);
    send_partial(5);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_state("mid_rst", 8'h00, 8'h00, 1'b0);
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'h1C); check_state("post_rst", 8'h1C, 8'h01, 1'b1);
    send_frame(8'hF0);
    send_frame(8'h1C); check_state("post_brk", 8'h1C, 8'h01, 1'b0);

    for (int i = 0; i < 254; i++) begin
      send_frame(8'h1C);
      send_frame(8'hF0);
      send_frame(8'h1C);
    end
    check_state("cnt_ff", 8'h1C, 8'hFF, 1'b0);
    send_frame(8'h1C); check_state("wrap_make", 8'h1C, 8'h00, 1'b1);
    send_frame(8'hF0);
    send_frame(8'h1C); check_state("wrap_brk",  8'h1C, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
PS/2 keyboard front end. It deserialises PS/2 device-to-host frames, interprets set-2 make/break scan codes, and exposes the current key code, a pressed flag and an 8-bit press counter. Board top level feeds key to a scan-code-to-ASCII table and to hex seven-segment drivers, blanking displays when is_press is low.

Parameters:
TIMEOUT, 16'd20000, clk cycles without a ps2_clk falling edge mid-frame before the partial frame is discarded

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
ps2_clk  input  1  raw PS/2 clock from keyboard (asynchronous)
ps2_data  input  1  raw PS/2 data from keyboard (asynchronous)
is_press  output  1  1 while the last reported key is held
count  output  8  number of distinct key presses since reset, mod 256
key  output  8  last make scan code received

Behaviour:
- Reset (rst=0, async): key=8'h00, count=8'h00, is_press=0. Bit counter, shift register, break/extend flags and timeout counter are cleared. Reset mid-frame aborts the frame.
- Sync: ps2_clk passes through 3 flops (s0,s1,s2). Falling edge fel = s2 & ~s1. ps2_data passes through 2 flops and is sampled when fel=1.
- Frame: 11 bits, LSB first: start(0), d0..d7, odd parity, stop(1). A 4-bit bit counter goes 0..10 and returns to 0 after the stop bit.
- Valid frame: start==0, stop==1, and XOR of d0..d7 and parity ==1. Invalid frames are dropped silently, leaving all outputs and flags unchanged.
- Timeout: while the bit counter is nonzero, count clk cycles since the last fel. On reaching TIMEOUT, clear the bit counter and shift register.
- Byte strobe: in cycle N (the cycle fel samples the stop bit), a registered byte_valid pulse is raised for one cycle in N+1. Outputs update on the clk edge ending N+1, so they are visible from N+2.
- Decode of the received byte b on byte_valid:
  - b==8'hE0: set extend flag. No output change.
  - b==8'hF0: set brk flag. No output change. Repeated F0 keeps brk set.
  - other b with brk=1: is_press<=0, key unchanged, count unchanged. Clear brk and extend.
  - other b with brk=0:
    - If is_press==0 or b!=key: count<=count+1 (wraps FF->00).
    - Then key<=b, is_press<=1. Clear extend.
    - Typematic repeat (is_press=1 and b==key) leaves count unchanged.
- Extended keys (E0 xx) report only xx in key; the extend flag is internal.
- Rolling to a second key while the first is held (make B after make A, no break) counts as a new press. A later break of either key drops is_press.
- count is plain 8-bit unsigned modulo arithmetic with no saturation.

Test Plan:
- Reset: assert rst=0 mid-frame after 5 bits -> key=00, count=00, is_press=0; next full frame decodes correctly.
- Press/release 'A': frames 1C, F0, 1C at ~10 kHz ps2_clk -> after 1C: key=1C, is_press=1, count=01; after F0 1C: is_press=0, key=1C, count=01.
- Typematic: 1C,1C,1C,F0,1C -> count=01 throughout, is_press high until the break.
- Bad parity frame 1C with even parity, then valid 32 -> 1C ignored, key=32, count=01.
- Extended: E0 75, E0 F0 75 -> key=75, is_press 1 then 0, count=01.
- Wrap: 256 press/release pairs of 1C starting from count=FF after 255 pairs -> count=00; rollover 1C then 32 without break -> count +2.
